uart_txd: RTL and testbench

UART_TXD -- requirements
Module: uart_txd

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_txd_if.sv | 22 ++
 rtl/uart_bps_gen.sv | 33 +++
 rtl/uart_txd.sv | 113 +++++++++++
 tb/tb_uart_txd.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: baud divider values, default oversampling and frame lengths.
// Used by uart_txd and the reusable baud generator.
package uart_pkg;

    localparam logic [15:0] BPS_4800   = 16'd648;
    localparam logic [15:0] BPS_9600   = 16'd325;
    localparam logic [15:0] BPS_19200  = 16'd160;
    localparam logic [15:0] BPS_115200 = 16'd26;

    localparam int TICKS_PER_BIT_DEF = 16;
    localparam int FRAME_LEN_NOPAR   = 10;
    localparam int FRAME_LEN_PAR     = 11;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_e;

    function automatic logic [15:0] bps_div(input logic [1:0] sel);
        case (sel)
            2'b00:   return BPS_4800;
            2'b01:   return BPS_9600;
            2'b10:   return BPS_19200;
            default: return BPS_115200;
        endcase
    endfunction

endpackage

// File: rtl/uart_txd_if.sv
// Request/status bundle between a UART transmitter and its user.
// The master side issues bytes; the slave side (uart_txd) serialises them.
interface uart_txd_if;

    logic [1:0] bps_set;
    logic       send_en;
    logic [7:0] data_byte;
    logic       txd;
    logic       tx_done;
    logic       uart_state;

    modport master (
        output bps_set, send_en, data_byte,
        input  txd, tx_done, uart_state
    );

    modport slave (
        input  bps_set, send_en, data_byte,
        output txd, tx_done, uart_state
    );

endinterface

// File: rtl/uart_bps_gen.sv
// Baud tick generator: counts 0..div while enabled and pulses tick on the terminal count,
// so ticks are div+1 clocks apart. Shared with the receiver.
module uart_bps_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] div_cnt_q;
    logic [15:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!enable || (div_cnt_q == div)) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 16'd1;
        end
    end

    assign tick = enable && (div_cnt_q == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/uart_txd.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, stop.
// Define UART_TX_PARITY_EN to compile in the parity bit (11-bit frame).
module uart_txd
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_txd_if.slave  bus
);

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_LEN = FRAME_LEN_PAR;
`else
    localparam int FRAME_LEN = FRAME_LEN_NOPAR;
`endif
    localparam int                TICK_W    = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = 1;
    localparam logic [3:0]        BIT_LAST  = 4'(FRAME_LEN - 1);

    tx_state_e         state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic [1:0]        bps_q, bps_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic              txd_q, txd_d;
    logic              tx_done_q, tx_done_d;
    logic              tick;
    logic [15:0]       div;

    // Line level for frame position idx: 0 start, 1..8 data, then parity/stop.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] d);
        logic [2:0] pos;
        pos = 3'(idx - 4'd1);
        if (idx == 4'd0) return 1'b0;
        if (idx <= 4'd8) return d[pos];
`ifdef UART_TX_PARITY_EN
        if (idx == 4'd9) return ^d;
`endif
        return 1'b1;
    endfunction

    assign div = bps_div(bps_q);

    uart_bps_gen u_bps_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state_q == TX_BUSY),
        .div    (div),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bps_d      = bps_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        txd_d      = txd_q;
        tx_done_d  = 1'b0;
        if (state_q == TX_IDLE) begin
            if (bus.send_en) begin
                state_d = TX_BUSY;
                data_d  = bus.data_byte;
                bps_d   = bus.bps_set;
                txd_d   = 1'b0;
            end
        end else if (tick) begin
            if (tick_cnt_q != TICK_LAST) begin
                tick_cnt_d = tick_cnt_q + TICK_ONE;
            end else begin
                tick_cnt_d = '0;
                // Last tick of the stop bit closes the frame on this edge.
                if (bit_idx_q == BIT_LAST) begin
                    state_d   = TX_IDLE;
                    bit_idx_d = '0;
                    txd_d     = 1'b1;
                    tx_done_d = 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    txd_d     = frame_bit(bit_idx_q + 4'd1, data_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TX_IDLE;
            data_q     <= '0;
            bps_q      <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            txd_q      <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            bps_q      <= bps_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            txd_q      <= txd_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign bus.txd        = txd_q;
    assign bus.tx_done    = tx_done_q;
    assign bus.uart_state = (state_q == TX_BUSY);

endmodule

// File: tb/tb_uart_txd.sv
// Directed bench for uart_txd: frame timing/bit order, ignored mid-frame requests,
// back-to-back send on tx_done, asynchronous reset abort and baud latching.
module tb_uart_txd;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    uart_txd_if bus ();

    uart_txd #(.TICKS_PER_BIT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input int k, input logic [7:0] d);
        logic [7:0] sh;
        if (k == 0) return 1'b0;
        if (k <= 8) begin
            sh = d >> (k - 1);
            return sh[0];
        end
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called on a negedge: request goes up for exactly the next posedge.
    task automatic drive_start(input logic [7:0] d, input logic [1:0] bps);
        bus.data_byte = d;
        bus.bps_set   = bps;
        bus.send_en   = 1'b1;
    endtask

    // c counts posedges since acceptance; sampled on negedges.
    task automatic track_frame(input string tag, input logic [7:0] d, input int t,
                               input int poke_at, input logic [1:0] poke_bps,
                               input bit chain, input logic [7:0] chain_d);
        @(negedge clk);
        bus.send_en = 1'b0;
        for (int c = 0; c <= NBITS * t; c++) begin
            if (c != 0) @(negedge clk);
            if (c == poke_at) begin
                bus.send_en   = 1'b1;
                bus.data_byte = 8'hFF;
                bus.bps_set   = poke_bps;
            end else if (c == poke_at + 1) begin
                bus.send_en = 1'b0;
            end
            if (c == 0) begin
                chk({tag, " state@0"}, bus.uart_state, 1'b1);
                chk({tag, " done@0"}, bus.tx_done, 1'b0);
            end
            if (c < NBITS * t && ((c % t) == 0 || (c % t) == t - 1))
                chk($sformatf("%s bit%0d c%0d", tag, c / t, c), bus.txd, exp_bit(c / t, d));
            if (c == NBITS * t - 1) begin
                chk({tag, " done_early"}, bus.tx_done, 1'b0);
                chk({tag, " state_end-1"}, bus.uart_state, 1'b1);
            end
            if (c == NBITS * t) begin
                chk({tag, " done_pulse"}, bus.tx_done, 1'b1);
                chk({tag, " state_end"}, bus.uart_state, 1'b0);
                chk({tag, " txd_end"}, bus.txd, 1'b1);
                if (chain) begin
                    bus.data_byte = chain_d;
                    bus.send_en   = 1'b1;
                end
            end
        end
        if (!chain) begin
            @(negedge clk);
            chk({tag, " done_width"}, bus.tx_done, 1'b0);
            chk({tag, " idle_txd"}, bus.txd, 1'b1);
            chk({tag, " idle_state"}, bus.uart_state, 1'b0);
        end
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int seen;
        rst_n         = 1'b0;
        bus.send_en   = 1'b0;
        bus.data_byte = 8'h00;
        bus.bps_set   = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst txd", bus.txd, 1'b1);
        chk("rst done", bus.tx_done, 1'b0);
        chk("rst state", bus.uart_state, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle txd", bus.txd, 1'b1);

        // 9600 frame; mid-frame request with 0xFF and a switch to 115200 must not disturb it
        drive_start(8'h55, 2'b01);
        track_frame("f55", 8'h55, 5216, 20000, 2'b11, 1'b0, 8'h00);

        // Next frame picks up 115200
        drive_start(8'hA3, 2'b11);
        track_frame("fA3", 8'hA3, 432, -1, 2'b11, 1'b0, 8'h00);

        // Ignored mid-frame 0xFF, then 0x34 requested in the tx_done cycle
        drive_start(8'h12, 2'b11);
        track_frame("f12", 8'h12, 432, 1500, 2'b11, 1'b1, 8'h34);
        track_frame("f34", 8'h34, 432, -1, 2'b11, 1'b0, 8'h00);

        // Reset during D4 of 0xF0
        drive_start(8'hF0, 2'b11);
        @(negedge clk);
        bus.send_en = 1'b0;
        repeat (5 * 432 + 200) @(negedge clk);
        chk("f0 D4 txd", bus.txd, 1'b1);
        chk("f0 D4 state", bus.uart_state, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort state", bus.uart_state, 1'b0);
        chk("abort txd", bus.txd, 1'b1);
        chk("abort done", bus.tx_done, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tx_done !== 1'b0 || bus.uart_state !== 1'b0) seen = 1;
        end
        chk("post abort quiet", seen, 0);
        drive_start(8'h0F, 2'b11);
        track_frame("f0F", 8'h0F, 432, -1, 2'b11, 1'b0, 8'h00);

        // 19200 start bit length, then reset while txd is low (D1 of 0x01)
        drive_start(8'h01, 2'b10);
        @(negedge clk);
        bus.send_en = 1'b0;
        n = 0;
        while (bus.txd == 1'b0 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("19200 start len", n, 2576);
        repeat (2576 + 100) @(negedge clk);
        chk("19200 D1 txd", bus.txd, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async txd", bus.txd, 1'b1);
        chk("async state", bus.uart_state, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst txd", bus.txd, 1'b1);
        chk("post rst done", bus.tx_done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
